// File: rtl/lc3b_regfile_sb.sv
// LC-3b general-purpose register file: one write port, two registered read ports,
// optional write-to-read forwarding and a per-register busy scoreboard for RAW hazards.
module lc3b_regfile_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int LINK_REG = 7,
  parameter int BYPASS   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    link_sel,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_W-1:0]       rd_addr1,
  input  logic [ADDR_W-1:0]       rd_addr2,
  output logic [DATA_W-1:0]       rd_data1,
  output logic [DATA_W-1:0]       rd_data2,
  input  logic                    issue_en,
  input  logic [ADDR_W-1:0]       issue_addr,
  input  logic                    sb_clear,
  output logic                    hazard1,
  output logic                    hazard2,
  output logic [(2**ADDR_W)-1:0]  busy_vec
);

  localparam int NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);
  localparam logic BYP = (BYPASS != 0);

  logic [ADDR_W-1:0] dest;
  logic [DATA_W-1:0] regs_reg [NUM_REGS];
  logic [DATA_W-1:0] rd_data1_next;
  logic [DATA_W-1:0] rd_data2_next;
  logic              fwd1;
  logic              fwd2;
  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;

  assign dest = link_sel ? LINK_IDX : wr_addr;

  // Storage must clear asynchronously, so it is built from flops rather than RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wr_en) begin
      regs_reg[dest] <= wr_data;
    end
  end

  assign fwd1 = BYP && wr_en && (dest == rd_addr1);
  assign fwd2 = BYP && wr_en && (dest == rd_addr2);

  always_comb begin
    rd_data1_next = fwd1 ? wr_data : regs_reg[rd_addr1];
    rd_data2_next = fwd2 ? wr_data : regs_reg[rd_addr2];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data1 <= '0;
      rd_data2 <= '0;
    end else if (rd_en) begin
      rd_data1 <= rd_data1_next;
      rd_data2 <= rd_data2_next;
    end
  end

  // Per-register busy priority: flush, then a fresh issue, then the retiring write.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      assign busy_next[gi] = sb_clear                                    ? 1'b0 :
                             (issue_en && (issue_addr == ADDR_W'(gi)))   ? 1'b1 :
                             (wr_en && (dest == ADDR_W'(gi)))            ? 1'b0 :
                                                                           busy_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy_vec = busy_reg;
  assign hazard1  = busy_reg[rd_addr1] & ~fwd1;
  assign hazard2  = busy_reg[rd_addr2] & ~fwd2;

endmodule

// File: tb/tb_lc3b_regfile_sb.sv
// Bench for lc3b_regfile_sb: directed vector table, async-reset/hold sequences and
// randomized traffic against a behavioural model, on forwarding and non-forwarding instances.
module tb_lc3b_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, link_sel, rd_en, issue_en, sb_clear;
  logic [2:0]  wr_addr, rd_addr1, rd_addr2, issue_addr;
  logic [15:0] wr_data;
  logic [15:0] rd_data1, rd_data2, rd_data1_b0, rd_data2_b0;
  logic        hazard1, hazard2, hazard1_b0, hazard2_b0;
  logic [7:0]  busy_vec, busy_vec_b0;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  lc3b_regfile_sb #(.DATA_W(16), .ADDR_W(3), .LINK_REG(7), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .link_sel(link_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .issue_en(issue_en), .issue_addr(issue_addr),
    .sb_clear(sb_clear), .hazard1(hazard1), .hazard2(hazard2), .busy_vec(busy_vec)
  );

  lc3b_regfile_sb #(.DATA_W(16), .ADDR_W(3), .LINK_REG(7), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .link_sel(link_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1_b0), .rd_data2(rd_data2_b0), .issue_en(issue_en), .issue_addr(issue_addr),
    .sb_clear(sb_clear), .hazard1(hazard1_b0), .hazard2(hazard2_b0), .busy_vec(busy_vec_b0)
  );

  typedef struct {
    logic        we, ls;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        re;
    logic [2:0]  ra1, ra2;
    logic        ie;
    logic [2:0]  ia;
    logic        clr;
    logic [15:0] e1, e2, e1b0;
    logic [7:0]  eb;
    logic        h1, h2;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, ls, input logic [2:0] wa, input logic [15:0] wd,
                     input logic re, input logic [2:0] ra1, ra2, input logic ie,
                     input logic [2:0] ia, input logic clr,
                     input logic [15:0] e1, e2, e1b0, input logic [7:0] eb,
                     input logic h1, h2);
    vec_t v;
    v.we = we; v.ls = ls; v.wa = wa; v.wd = wd; v.re = re; v.ra1 = ra1; v.ra2 = ra2;
    v.ie = ie; v.ia = ia; v.clr = clr; v.e1 = e1; v.e2 = e2; v.e1b0 = e1b0;
    v.eb = eb; v.h1 = h1; v.h2 = h2;
    vq.push_back(v);
  endtask

  task automatic idle();
    wr_en = 0; link_sel = 0; wr_addr = 0; wr_data = 0; rd_en = 0;
    rd_addr1 = 0; rd_addr2 = 0; issue_en = 0; issue_addr = 0; sb_clear = 0;
  endtask

  task automatic drive(input vec_t v);
    wr_en = v.we; link_sel = v.ls; wr_addr = v.wa; wr_data = v.wd; rd_en = v.re;
    rd_addr1 = v.ra1; rd_addr2 = v.ra2; issue_en = v.ie; issue_addr = v.ia; sb_clear = v.clr;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Behavioural reference state
  logic [15:0] m_regs [8];
  logic [7:0]  m_busy;
  logic [15:0] m_rd1, m_rd2, m_rd1_b0, m_rd2_b0;

  initial begin
    logic [2:0]  d;
    logic        eh1, eh2;
    logic [15:0] hold;

    idle();
    rst = 1'b0;
    #1;
    check("reset_rd1_async", {16'h0, rd_data1}, 32'h0);
    do_reset();
    #1;
    check("reset_busy", {24'h0, busy_vec}, 32'h0);

    // ---- directed table (expected values are after the edge; hazards before it) ----
    add(0,0,0,16'h0000, 1,3,7, 0,0,0, 16'h0000,16'h0000,16'h0000, 8'h00, 0,0);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] val;
      val = 16'(16'h1110 * i + i);
      add(1,0,3'(i),val, 0,3,7, 0,0,0, 16'h0000,16'h0000,16'h0000, 8'h00, 0,0);
    end
    add(0,0,0,16'h0000, 1,0,7, 0,0,0, 16'h0000,16'h7777,16'h0000, 8'h00, 0,0);
    add(0,0,0,16'h0000, 1,3,3, 0,0,0, 16'h3333,16'h3333,16'h3333, 8'h00, 0,0);
    add(1,1,2,16'h3000, 0,3,3, 0,0,0, 16'h3333,16'h3333,16'h3333, 8'h00, 0,0);
    add(0,0,0,16'h0000, 1,7,2, 0,0,0, 16'h3000,16'h2222,16'h3000, 8'h00, 0,0);
    add(0,0,0,16'h0000, 0,7,2, 1,7,0, 16'h3000,16'h2222,16'h3000, 8'h80, 0,0);
    add(1,1,2,16'h3002, 0,7,2, 0,0,0, 16'h3000,16'h2222,16'h3000, 8'h00, 0,0);
    add(1,0,5,16'h00AA, 0,5,5, 0,0,0, 16'h3000,16'h2222,16'h3000, 8'h00, 0,0);
    add(1,0,5,16'h5555, 1,5,5, 0,0,0, 16'h5555,16'h5555,16'h00AA, 8'h00, 0,0);
    add(0,0,0,16'h0000, 0,5,4, 1,4,0, 16'h5555,16'h5555,16'h00AA, 8'h10, 0,0);
    add(0,0,0,16'h0000, 0,5,4, 0,0,0, 16'h5555,16'h5555,16'h00AA, 8'h10, 0,1);
    add(1,0,4,16'h4A4A, 0,5,4, 0,0,0, 16'h5555,16'h5555,16'h00AA, 8'h00, 0,0);
    add(0,0,0,16'h0000, 0,5,4, 1,4,0, 16'h5555,16'h5555,16'h00AA, 8'h10, 0,0);
    add(1,0,4,16'h0404, 0,5,4, 1,4,0, 16'h5555,16'h5555,16'h00AA, 8'h10, 0,0);
    add(0,0,0,16'h0000, 0,5,4, 1,2,1, 16'h5555,16'h5555,16'h00AA, 8'h00, 0,1);
    add(0,0,0,16'h0000, 1,4,1, 0,0,0, 16'h0404,16'h1111,16'h0404, 8'h00, 0,0);

    foreach (vq[k]) begin
      drive(vq[k]);
      #1;
      check($sformatf("v%0d_hazard1", k), {31'h0, hazard1}, {31'h0, vq[k].h1});
      check($sformatf("v%0d_hazard2", k), {31'h0, hazard2}, {31'h0, vq[k].h2});
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_rd_data1", k), {16'h0, rd_data1}, {16'h0, vq[k].e1});
      check($sformatf("v%0d_rd_data2", k), {16'h0, rd_data2}, {16'h0, vq[k].e2});
      check($sformatf("v%0d_rd_data1_nobyp", k), {16'h0, rd_data1_b0}, {16'h0, vq[k].e1b0});
      check($sformatf("v%0d_busy_vec", k), {24'h0, busy_vec}, {24'h0, vq[k].eb});
    end
    idle();

    // ---- async reset mid-operation ----
    wr_en = 1; wr_addr = 1; wr_data = 16'hBEEF; issue_en = 1; issue_addr = 1;
    @(posedge clk); @(negedge clk);
    idle(); issue_en = 1; issue_addr = 2; rd_en = 1; rd_addr1 = 1; rd_addr2 = 1;
    @(posedge clk); @(negedge clk);
    idle();
    check("pre_rst_rd1", {16'h0, rd_data1}, 32'hBEEF);
    check("pre_rst_busy", {24'h0, busy_vec}, 32'h06);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_rd1", {16'h0, rd_data1}, 32'h0);
    check("async_rst_rd2", {16'h0, rd_data2}, 32'h0);
    check("async_rst_busy", {24'h0, busy_vec}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    rd_en = 1; rd_addr1 = 1; rd_addr2 = 2;
    @(posedge clk); @(negedge clk);
    check("post_rst_r1", {16'h0, rd_data1}, 32'h0);

    // ---- rd_en=0 hold across writes to the read address ----
    rd_en = 1; rd_addr1 = 3; wr_en = 1; wr_addr = 3; wr_data = 16'h1234;
    @(posedge clk); @(negedge clk);
    hold = 16'h1234;
    check("hold_capture", {16'h0, rd_data1}, {16'h0, hold});
    rd_en = 0;
    for (int n = 0; n < 3; n++) begin
      wr_data = 16'(16'hA000 + n);
      @(posedge clk); @(negedge clk);
      check($sformatf("hold_%0d", n), {16'h0, rd_data1}, {16'h0, hold});
    end
    idle();

    // ---- randomized traffic vs. reference model ----
    do_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_busy = '0; m_rd1 = '0; m_rd2 = '0; m_rd1_b0 = '0; m_rd2_b0 = '0;
    for (int n = 0; n < 300; n++) begin
      wr_en      = ($urandom_range(1) == 1);
      link_sel   = ($urandom_range(3) == 0);
      wr_addr    = 3'($urandom_range(7));
      wr_data    = 16'($urandom);
      rd_en      = ($urandom_range(3) != 0);
      rd_addr1   = 3'($urandom_range(7));
      rd_addr2   = 3'($urandom_range(7));
      issue_en   = ($urandom_range(2) == 0);
      issue_addr = 3'($urandom_range(7));
      sb_clear   = ($urandom_range(15) == 0);
      #1;
      d = link_sel ? 3'd7 : wr_addr;
      eh1 = m_busy[rd_addr1] && !(wr_en && d == rd_addr1);
      eh2 = m_busy[rd_addr2] && !(wr_en && d == rd_addr2);
      check($sformatf("r%0d_hazard1", n), {31'h0, hazard1}, {31'h0, eh1});
      check($sformatf("r%0d_hazard2", n), {31'h0, hazard2}, {31'h0, eh2});
      check($sformatf("r%0d_hazard1_nobyp", n), {31'h0, hazard1_b0}, {31'h0, m_busy[rd_addr1]});
      if (rd_en) begin
        m_rd1    = (wr_en && d == rd_addr1) ? wr_data : m_regs[rd_addr1];
        m_rd2    = (wr_en && d == rd_addr2) ? wr_data : m_regs[rd_addr2];
        m_rd1_b0 = m_regs[rd_addr1];
        m_rd2_b0 = m_regs[rd_addr2];
      end
      if (sb_clear) m_busy = '0;
      else begin
        if (wr_en) m_busy[d] = 1'b0;
        if (issue_en) m_busy[issue_addr] = 1'b1;
      end
      if (wr_en) m_regs[d] = wr_data;
      @(posedge clk); @(negedge clk);
      check($sformatf("r%0d_rd_data1", n), {16'h0, rd_data1}, {16'h0, m_rd1});
      check($sformatf("r%0d_rd_data2", n), {16'h0, rd_data2}, {16'h0, m_rd2});
      check($sformatf("r%0d_rd_data1_nobyp", n), {16'h0, rd_data1_b0}, {16'h0, m_rd1_b0});
      check($sformatf("r%0d_rd_data2_nobyp", n), {16'h0, rd_data2_b0}, {16'h0, m_rd2_b0});
      check($sformatf("r%0d_busy_vec", n), {24'h0, busy_vec}, {24'h0, m_busy});
      check($sformatf("r%0d_busy_vec_nobyp", n), {24'h0, busy_vec_b0}, {24'h0, m_busy});
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/lc3b_regfile_sb.md
Name: lc3b_regfile_sb

Overview:
- Parametrised general-purpose register file for the LC-3b datapath: one write port, two registered read ports, optional write-to-read bypass.
- Per-register busy scoreboard so the control FSM can detect RAW hazards on in-flight destination writes.
- Sits between the IR decode/DRMUX/SR1MUX logic and the ALU/address adders; consumes BUS as write data.

Parameters:
- DATA_W, 16, register and bus width in bits.
- ADDR_W, 3, register index width; NUM_REGS = 2**ADDR_W (derived localparam, not overridable).
- LINK_REG, 7, index written when link_sel=1 (JSR/TRAP return address).
- BYPASS, 1, 1 = same-cycle write data forwarded to read outputs and hazard masked; 0 = no forwarding.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- wr_en  in  1  write strobe (LD.REG).
- link_sel  in  1  1 = write goes to LINK_REG, wr_addr ignored (DRMUX).
- wr_addr  in  ADDR_W  destination index when link_sel=0.
- wr_data  in  DATA_W  write data (BUS).
- rd_en  in  1  1 = capture new read data; 0 = hold outputs.
- rd_addr1  in  ADDR_W  source 1 index.
- rd_addr2  in  ADDR_W  source 2 index.
- rd_data1  out  DATA_W  registered source 1 data.
- rd_data2  out  DATA_W  registered source 2 data.
- issue_en  in  1  marks a destination as pending (instruction issued with a writeback).
- issue_addr  in  ADDR_W  pending destination index.
- sb_clear  in  1  synchronous flush of all busy bits (pipeline flush).
- hazard1  out  1  combinational: source 1 has a pending, unsatisfied write.
- hazard2  out  1  combinational: source 2 has a pending, unsatisfied write.
- busy_vec  out  NUM_REGS  registered busy bits, bit i = register i pending.

Behaviour:
- Effective destination: dest = link_sel ? LINK_REG : wr_addr. Any index, including 0, is writable.
- Reset (rst=0, asynchronous): all NUM_REGS registers = 0, rd_data1 = rd_data2 = 0, busy_vec = 0. Release is synchronous to the next rising edge.
- Write: on a rising edge with wr_en=1, reg[dest] <= wr_data. Exactly one register changes; all others hold.
- Read latency: 1 cycle. On a rising edge with rd_en=1, rd_dataN <= reg[rd_addrN]. With rd_en=0, rd_dataN hold their last value regardless of writes.
- Same-edge write and read to one index:
  - BYPASS=1: rd_dataN captures wr_data (new value).
  - BYPASS=0: rd_dataN captures the old register contents.
- Both read ports may address the same register; both get identical data.
- Scoreboard, per register i, evaluated each edge:
  - sb_clear=1: busy[i] <= 0 for all i. Overrides issue and write.
  - Else if issue_en=1 and issue_addr==i: busy[i] <= 1. Issue wins over a same-edge write to i, because a new writer is now pending.
  - Else if wr_en=1 and dest==i: busy[i] <= 0.
  - Else: hold.
- A write to a non-busy register is legal and leaves busy=0.
- Hazard: hazardN = busy[rd_addrN] & ~(BYPASS & wr_en & (dest==rd_addrN)). Purely combinational from current inputs and busy_vec; no dependence on rd_en.
- No other state. Writes and reads proceed regardless of busy; stalling is the controller's job.
- Asserting reset mid-operation discards any pending write and all busy bits. No partial updates.

Test Plan:
- Reset then reads: assert rst=0 for 2 cycles, release, rd_en=1 with rd_addr1=3 and rd_addr2=7 -> one cycle later rd_data1=0x0000, rd_data2=0x0000, busy_vec=0x00.
- Write/read all registers: write 0x1110*i+i to R0..R7 on successive cycles, then read pairs (0,7), (3,3) -> values match after 1-cycle latency. Every other register is unchanged after each write.
- Link write: link_sel=1, wr_addr=2, wr_data=0x3000 -> R7=0x3000 and R2 unchanged. Then issue_addr=7 busy, link write clears busy_vec[7].
- Bypass: BYPASS=1, R5=0x00AA, same edge wr_en to R5 with 0x5555, rd_en=1, rd_addr1=5 -> rd_data1=0x5555. Repeat with BYPASS=0 -> rd_data1=0x00AA.
- Scoreboard: issue R4 -> busy_vec=0x10; rd_addr2=4 -> hazard2=1; wr_en to R4 with BYPASS=1 -> hazard2=0 that cycle, busy_vec=0x00 next. Same-edge issue_addr=4 and write R4 -> busy_vec[4] stays 1. sb_clear with issue_en the same edge -> busy_vec=0x00.
- Async reset mid-operation: rst=0 between clock edges while R1=0xBEEF and busy_vec=0x06 -> registers, outputs and busy_vec read 0 immediately, before the next edge. rd_en=0 hold: rd_data stays constant across 3 writes to the read address.
